// File: rtl/spi_ram_slave.sv
// spi_ram_slave: SPI slave front end for the single-port RAM.
// Collects (ADDR_SIZE+2)-bit command words from MOSI into rx_data/rx_valid and
// serialises the RAM read byte (tx_data/tx_valid) back out on MISO, MSB first.
// All logic runs on clk; SPI bits are sampled once per rising edge.
// Optional macro SPI_RAM_SLAVE_ASSERT_EN compiles in protocol assertions.
module spi_ram_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid
);

  localparam int          W        = ADDR_SIZE + 2;
  localparam logic [3:0]  LAST_BIT = 4'(W - 1);
  localparam int          TXCW     = $clog2(ADDR_SIZE + 1);
  localparam logic [TXCW-1:0] TX_LAST = TXCW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, state_nxt;

  logic [3:0]           cnt, cnt_nxt;
  logic [W-2:0]         shift, shift_nxt;
  logic                 frame_done, frame_done_nxt;
  logic                 rd_addr_held, rd_addr_held_nxt;
  logic [ADDR_SIZE-1:0] tx_shift, tx_shift_nxt;
  logic [TXCW-1:0]      tx_cnt, tx_cnt_nxt;
  logic                 tx_busy, tx_busy_nxt;
  logic                 tx_sent, tx_sent_nxt;
  logic                 miso_nxt;
  logic [W-1:0]         rx_data_nxt;
  logic                 rx_valid_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; SS_n high always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_held) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath/output next values: payload shift, command capture, MISO serialiser
  always_comb begin
    cnt_nxt          = cnt;
    shift_nxt        = shift;
    frame_done_nxt   = frame_done;
    rd_addr_held_nxt = rd_addr_held;
    tx_shift_nxt     = tx_shift;
    tx_cnt_nxt       = tx_cnt;
    tx_busy_nxt      = tx_busy;
    tx_sent_nxt      = tx_sent;
    miso_nxt         = MISO;
    rx_data_nxt      = rx_data;
    rx_valid_nxt     = 1'b0;

    case (state)
      WRITE, READ_ADD, READ_DATA: begin
        if (!frame_done) begin
          shift_nxt = {shift[W-3:0], MOSI};
          if (cnt == LAST_BIT) begin
            rx_data_nxt    = {shift, MOSI};
            rx_valid_nxt   = 1'b1;
            frame_done_nxt = 1'b1;
            if (state == READ_ADD)       rd_addr_held_nxt = 1'b1;
            else if (state == READ_DATA) rd_addr_held_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else if (state == READ_DATA) begin
          if (tx_busy) begin
            if (tx_cnt != '0) begin
              miso_nxt     = tx_shift[ADDR_SIZE-1];
              tx_shift_nxt = {tx_shift[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_nxt   = tx_cnt - 1'b1;
            end else begin
              miso_nxt    = 1'b0;
              tx_busy_nxt = 1'b0;
              tx_sent_nxt = 1'b1;
            end
          end else if (!tx_sent && tx_valid) begin
            // First bit goes out on the same edge the byte is latched
            miso_nxt     = tx_data[ADDR_SIZE-1];
            tx_shift_nxt = {tx_data[ADDR_SIZE-2:0], 1'b0};
            tx_cnt_nxt   = TX_LAST;
            tx_busy_nxt  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Frame end: a 10th bit sampled together with SS_n high still completes the
    // command above, but all frame-local state is cleared here.
    if (SS_n) begin
      cnt_nxt        = '0;
      frame_done_nxt = 1'b0;
      tx_busy_nxt    = 1'b0;
      tx_sent_nxt    = 1'b0;
      miso_nxt       = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      shift        <= '0;
      frame_done   <= 1'b0;
      rd_addr_held <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_sent      <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      shift        <= shift_nxt;
      frame_done   <= frame_done_nxt;
      rd_addr_held <= rd_addr_held_nxt;
      tx_shift     <= tx_shift_nxt;
      tx_cnt       <= tx_cnt_nxt;
      tx_busy      <= tx_busy_nxt;
      tx_sent      <= tx_sent_nxt;
      MISO         <= miso_nxt;
      rx_data      <= rx_data_nxt;
      rx_valid     <= rx_valid_nxt;
    end
  end

`ifdef SPI_RAM_SLAVE_ASSERT_EN
  logic ss_q;
  logic rx_valid_q;

  // History of SS_n and rx_valid for the protocol checks below
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q       <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      ss_q       <= SS_n;
      rx_valid_q <= rx_valid;
    end
  end

  // Protocol invariants
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rx_valid && rx_valid_q))
        else $error("rx_valid high for two consecutive cycles");
      assert (cnt <= LAST_BIT)
        else $error("bit counter out of range: %0d", cnt);
      assert (state == READ_DATA || !MISO)
        else $error("MISO high outside READ_DATA");
      if (ss_q) begin
        assert (state == IDLE)
          else $error("state not IDLE after SS_n high");
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_slave.sv
// tb_spi_ram_slave: directed self-checking bench for spi_ram_slave.
// Inputs change 1ns after each rising edge; outputs are checked at that point,
// i.e. they show the values registered on the edge just taken.
module tb_spi_ram_slave;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  spi_ram_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rx_valid pulses seen on each edge
  always @(posedge clk) begin
    if (rx_valid) pulses = pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  // E0 (SS_n low in IDLE), E1 (selector), E2..E11 (payload MSB first).
  // With ss_up_last, SS_n is already high on the edge sampling bit 0.
  task automatic frame(input logic sel, input logic [9:0] w, input bit ss_up_last);
    SS_n = 1'b0; MOSI = 1'b0;
    tick();
    MOSI = sel;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      if (i == 0 && ss_up_last) SS_n = 1'b1;
      tick();
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1; MOSI = 1'b0;
    tick();
  endtask

  localparam logic [7:0] RD_BYTE = 8'hA5;

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_miso",     16'(MISO),     16'h0);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_rx_data",  16'(rx_data),  16'h000);
    rst = 1'b0;
    tick();

    // Read-data opcode with no address held: routed to READ_ADD, tx ignored
    frame(1'b1, 10'h300, 0);
    chk("route_rx_valid", 16'(rx_valid), 16'h1);
    chk("route_rx_data",  16'(rx_data),  16'h300);
    tick();                                   // E12
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();                                   // E13
    tx_valid = 1'b0; tx_data = '0;
    for (int i = 0; i < 9; i++) begin
      chk("route_miso_idle", 16'(MISO), 16'h0);
      tick();
    end
    end_frame();

    // Reset mid-frame, just before the last payload bit
    SS_n = 1'b0; MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      MOSI = 1'b1; tick();
    end
    rst = 1'b1; MOSI = 1'b1;
    tick();
    chk("mid_rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("mid_rst_rx_data",  16'(rx_data),  16'h000);
    chk("mid_rst_miso",     16'(MISO),     16'h0);
    rst = 1'b0;
    end_frame();
    tick();
    chk("mid_rst_no_pulse", 16'(pulses - p0), 16'h0);

    // Write address
    p0 = pulses;
    frame(1'b0, 10'h012, 0);
    chk("wa_rx_valid", 16'(rx_valid), 16'h1);
    chk("wa_rx_data",  16'(rx_data),  16'h012);
    for (int i = 0; i < 4; i++) begin
      MOSI = ~MOSI;
      tick();
      chk("wa_no_repulse", 16'(rx_valid), 16'h0);
    end
    end_frame();
    chk("wa_one_pulse", 16'(pulses - p0), 16'h1);

    // Write data
    p0 = pulses;
    frame(1'b0, 10'h1A5, 0);
    chk("wd_rx_valid", 16'(rx_valid), 16'h1);
    chk("wd_rx_data",  16'(rx_data),  16'h1A5);
    tick();
    chk("wd_pulse_end", 16'(rx_valid), 16'h0);
    end_frame();
    chk("wd_one_pulse", 16'(pulses - p0), 16'h1);

    // Abort after 5 payload bits
    p0 = pulses;
    SS_n = 1'b0; MOSI = 1'b0; tick();
    MOSI = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1; tick();
    end
    SS_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      MOSI = ~MOSI; tick();
    end
    MOSI = 1'b0;
    chk("abort_no_pulse", 16'(pulses - p0), 16'h0);
    chk("abort_rx_hold",  16'(rx_data),     16'h1A5);
    frame(1'b0, 10'h0C3, 0);
    chk("after_abort_valid", 16'(rx_valid), 16'h1);
    chk("after_abort_data",  16'(rx_data),  16'h0C3);
    end_frame();

    // Read address (reset cleared the held flag)
    frame(1'b1, 10'h212, 0);
    chk("ra_rx_valid", 16'(rx_valid), 16'h1);
    chk("ra_rx_data",  16'(rx_data),  16'h212);
    end_frame();

    // Read data: RAM answers at E12, MISO shifts A5 out on E13..E20
    frame(1'b1, 10'h300, 0);
    chk("rd_rx_valid", 16'(rx_valid), 16'h1);
    chk("rd_rx_data",  16'(rx_data),  16'h300);
    tick();                                   // E12
    chk("rd_miso_wait", 16'(MISO), 16'h0);
    tx_valid = 1'b1; tx_data = RD_BYTE;
    tick();                                   // E13
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      chk($sformatf("rd_miso_bit%0d", b), 16'(MISO), 16'(RD_BYTE[b]));
      tick();
    end
    chk("rd_miso_after", 16'(MISO), 16'h0);   // after E21
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("rd_second_tx_ignored", 16'(MISO), 16'h0);
    end_frame();
    chk("rd_miso_idle", 16'(MISO), 16'h0);

    // SS_n rises on the edge sampling the last payload bit
    p0 = pulses;
    frame(1'b0, 10'h2AA, 1);
    chk("late_ss_rx_valid", 16'(rx_valid), 16'h1);
    chk("late_ss_rx_data",  16'(rx_data),  16'h2AA);
    tick();
    chk("late_ss_pulse_end", 16'(rx_valid), 16'h0);
    chk("late_ss_one_pulse", 16'(pulses - p0), 16'h1);

    // Held flag cleared by the read-data frame: selector 1 goes to READ_ADD again
    frame(1'b1, 10'h2FE, 0);
    chk("reroute_rx_data", 16'(rx_data), 16'h2FE);
    tick();
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    chk("reroute_miso", 16'(MISO), 16'h0);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave.md
# spi_ram_slave

- Serial front end for the single-port RAM.
- Deserialises SPI frames from the master into 10-bit RAM commands (`rx_data`, `rx_valid`).
- Serialises the RAM's read byte (`tx_data`, `tx_valid`) back onto MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper; all logic runs on the system clock, with SPI bits sampled once per `clk` edge.

## Interface
- `ADDR_SIZE`, 8: RAM address/data byte width; frame payload is `ADDR_SIZE+2` bits.
- `clk` in 1: system clock, all sampling on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SS_n` in 1: slave select, active low; high ends any frame.
- `MOSI` in 1: serial data from master, MSB first.
- `tx_data` in `ADDR_SIZE`: read byte from RAM.
- `tx_valid` in 1: RAM read byte valid, single-cycle pulse.
- `MISO` out 1: serial read data to master, MSB first.
- `rx_data` out `ADDR_SIZE+2`: command word to RAM; `[9:8]` opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), `[7:0]` payload.
- `rx_valid` out 1: `rx_data` valid, single-cycle pulse.

## Operation
- States:
  - IDLE
  - CHK_CMD
  - WRITE
  - READ_ADD
  - READ_DATA
- Internal flag `rd_addr_held` is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes.
- IDLE: when `SS_n`=0 is sampled, go to CHK_CMD.
- CHK_CMD: the sampled MOSI bit is a selector only and is not stored.
  - MOSI=0 → WRITE.
  - MOSI=1 with `rd_addr_held`=0 → READ_ADD.
  - MOSI=1 with `rd_addr_held`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA:
  - Shift 10 MOSI bits into a shift register, MSB (`rx_data[9]`) first; a 4-bit counter runs 0..9.
  - On the edge sampling bit 9: `rx_data` ← full word and `rx_valid` ← 1 for exactly one cycle.
  - Opcode bits are passed through unchecked; the master owns opcode consistency.
- WRITE and READ_ADD after 10 bits: further MOSI ignored; no second `rx_valid` until a new frame.
- READ_DATA after 10 bits:
  - Wait for `tx_valid`.
  - On the edge where `tx_valid`=1 is sampled, latch `tx_data` and drive `MISO` ← `tx_data[7]`.
  - On the following 7 edges, shift out bits 6..0.
  - After that, `MISO` ← 0.
- `tx_valid` sampled outside the READ_DATA wait phase is ignored.
- `SS_n`=1 sampled in any state:
  - Next state IDLE, counter cleared, `MISO` ← 0.
  - A partial frame never asserts `rx_valid`.
  - `rd_addr_held` is unchanged.
- Reset values:
  - `MISO`=0, `rx_data`=0, `rx_valid`=0.
  - State IDLE, counter 0, `rd_addr_held`=0.

## Timing
- Edges are numbered from E0, the edge sampling `SS_n`=0 in IDLE.
- E1: CHK_CMD samples the selector bit.
- E2..E11: payload bits 9..0 sampled.
- `rx_valid`=1 during the cycle after E11 (registered).
- With the RAM responding at E12, `tx_valid` is high after E12.
  - E13 samples it; `MISO`=bit7 after E13.
  - Bit0 is after E20; `MISO`=0 after E21.
- Minimum frame length with `SS_n` low: 12 cycles for write/rd-addr; 21 cycles for rd-data, plus any extra RAM latency.
- `SS_n` may return high on the same edge `rx_valid` is registered (E11): `rx_valid` still pulses.
- Reset mid-frame: reset values on the next edge; no `rx_valid`; MISO stops.
- Back-to-back frames: `SS_n` high for at least 1 sampled edge between frames.

## Configuration
- `SPI_RAM_SLAVE_ASSERT_EN` defined: immediate assertions compiled in, checking:
  - `rx_valid` is never high for two consecutive cycles.
  - The counter never exceeds 9.
  - `MISO`=0 whenever the state is not READ_DATA.
  - The state returns to IDLE on the edge after `SS_n`=1 is sampled.
- Not defined: no assertion logic, identical functional behaviour.

## Test plan
- Reset with `rst`=1 for 2 cycles → `MISO`=0, `rx_valid`=0, `rx_data`=0; with `SS_n`=0 and selector MOSI=1, the frame goes to READ_ADD.
- Write address: `SS_n`=0, MOSI 0 then `00_0001_0010` → one `rx_valid` pulse with `rx_data`=10'h012 after E11; no further pulse until `SS_n` high.
- Write data: MOSI 0 then `01_1010_0101` → `rx_data`=10'h1A5, single pulse.
- Read address then read data:
  - Frame 1: MOSI 1 then `10_0001_0010` → `rx_data`=10'h212.
  - Frame 2: MOSI 1 then `11_0000_0000` → `rx_data`=10'h300.
  - Drive `tx_valid`=1 with `tx_data`=8'hA5 at E12 → MISO 1,0,1,0,0,1,0,1 on E13..E20, then 0.
- Abort: `SS_n` high after 5 payload bits of a write frame → no `rx_valid`; state IDLE next cycle; the next full frame decodes correctly.
- Selector routing: read-data frame with `rd_addr_held`=0 → goes to READ_ADD (not READ_DATA); a `tx_valid` pulse there is ignored and `MISO` stays 0.
